// File: rtl/key_encoder.sv
// Keypad front-end: synchronises and debounces 16 buttons, picks the highest key, scales its period by octave.
// Define NOTE_HOLD_EN to sustain the last note's divider after all keys release.
module key_encoder #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int OCT_RESET       = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [12:0] keys,
    input  logic        octave_up,
    input  logic        octave_down,
    input  logic        mode_btn,
    output logic [17:0] divider,
    output logic [1:0]  mode,
    output logic        note_on,
    output logic [2:0]  octave
);
    localparam int          NUM_IN   = 16;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]  OCT_MAX  = 3'd4;

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] r_sync1;
    logic [NUM_IN-1:0] r_sync2;
    logic [NUM_IN-1:0] r_db;
    logic [15:0]       r_cnt [NUM_IN];
    logic [2:0]        r_btn_prev;
    logic [2:0]        w_btn_rise;
    logic              w_any;
    logic [3:0]        w_key_idx;
    logic [3:0]        w_sel_idx;
    logic              w_sounding;
    logic [17:0]       w_scaled;
    logic [17:0]       r_divider;
    logic              r_note_on;
    logic [2:0]        r_octave;
    logic [1:0]        r_mode;

    assign w_raw = {mode_btn, octave_down, octave_up, keys};

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: these counters are plain flops, not a RAM, so resetting them is legal and keeps filtering clean after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_db       <= '0;
            r_btn_prev <= '0;
            for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
        end else begin
            r_btn_prev <= r_db[15:13];
            for (int i = 0; i < NUM_IN; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Bit 0 = octave up, bit 1 = octave down, bit 2 = mode.
    assign w_btn_rise = r_db[15:13] & ~r_btn_prev;
    assign w_any      = |r_db[12:0];

    // NOTE: a default before the loop keeps this combinational block free of latches.
    always_comb begin
        w_key_idx = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (r_db[i]) w_key_idx = 4'(i);
        end
    end

    function automatic logic [17:0] note_period(input logic [3:0] idx);
        case (idx)
            4'd0:    note_period = 18'd152891;
            4'd1:    note_period = 18'd144308;
            4'd2:    note_period = 18'd136210;
            4'd3:    note_period = 18'd128564;
            4'd4:    note_period = 18'd121349;
            4'd5:    note_period = 18'd114538;
            4'd6:    note_period = 18'd108109;
            4'd7:    note_period = 18'd102042;
            4'd8:    note_period = 18'd96315;
            4'd9:    note_period = 18'd90909;
            4'd10:   note_period = 18'd85806;
            4'd11:   note_period = 18'd80991;
            4'd12:   note_period = 18'd76445;
            default: note_period = 18'd0;
        endcase
    endfunction

`ifdef NOTE_HOLD_EN
    logic [3:0] r_last_idx;
    logic       r_have_note;

    // Remember the index, not the divider, so a held note still follows octave changes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_idx  <= '0;
            r_have_note <= 1'b0;
        end else if (w_any) begin
            r_last_idx  <= w_key_idx;
            r_have_note <= 1'b1;
        end
    end

    assign w_sel_idx  = w_any ? w_key_idx : r_last_idx;
    assign w_sounding = w_any | r_have_note;
`else
    assign w_sel_idx  = w_key_idx;
    assign w_sounding = w_any;
`endif

    assign w_scaled = note_period(w_sel_idx) >> r_octave;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_divider <= '0;
            r_note_on <= 1'b0;
            r_octave  <= 3'(OCT_RESET);
            r_mode    <= '0;
        end else begin
            r_divider <= w_sounding ? w_scaled : '0;
            r_note_on <= w_any;
            if (w_btn_rise[0] && !w_btn_rise[1] && r_octave != OCT_MAX)
                r_octave <= r_octave + 3'd1;
            else if (w_btn_rise[1] && !w_btn_rise[0] && r_octave != 3'd0)
                r_octave <= r_octave - 3'd1;
            if (w_btn_rise[2])
                r_mode <= r_mode + 2'd1;
        end
    end

    assign divider = r_divider;
    assign note_on = r_note_on;
    assign octave  = r_octave;
    assign mode    = r_mode;
endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: directed scenarios plus random button activity, scored cycle by cycle
// against a window-based reference model.
`timescale 1ns/1ps
module tb_key_encoder;
    localparam int D       = 4;
    localparam int OCT_RST = 2;
`ifdef NOTE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic [17:0] div;
        logic [1:0]  mode;
        logic        note;
        logic [2:0]  oct;
    } out_t;

    logic        clk;
    logic        nrst;
    logic [12:0] keys;
    logic        octave_up;
    logic        octave_down;
    logic        mode_btn;
    logic [17:0] divider;
    logic [1:0]  mode;
    logic        note_on;
    logic [2:0]  octave;

    int n_checks = 0;
    int n_errors = 0;

    out_t exp_q[$];

    key_encoder #(.DEBOUNCE_CYCLES(D), .OCT_RESET(OCT_RST)) dut (
        .clk(clk), .nrst(nrst), .keys(keys), .octave_up(octave_up),
        .octave_down(octave_down), .mode_btn(mode_btn), .divider(divider),
        .mode(mode), .note_on(note_on), .octave(octave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned NOTE_TAB [13] = '{152891, 144308, 136210, 128564, 121349, 114538,
                                   108109, 102042, 96315, 90909, 85806, 80991, 76445};
    logic [15:0] hist[$];     // raw input vectors, newest at index 0
    logic [15:0] m_db;
    logic [15:0] m_prev;
    int          m_oct;
    int          m_mode;
    int unsigned m_div;
    logic        m_note;
    int          m_held;

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_front(16'h0);
        m_db   = '0;
        m_prev = '0;
        m_oct  = OCT_RST;
        m_mode = 0;
        m_div  = 0;
        m_note = 1'b0;
        m_held = -1;
    endtask

    task automatic model_step();
        int   idx;
        bit   up, dn, stable;
        logic [15:0] old_db;
        if (!nrst) begin
            model_reset();
        end else begin
            idx = -1;
            for (int k = 12; k >= 0; k--) begin
                if (m_db[k]) begin idx = k; break; end
            end
            if (idx >= 0) begin
                m_div  = NOTE_TAB[idx] >> m_oct;
                m_note = 1'b1;
                m_held = idx;
            end else begin
                m_note = 1'b0;
                m_div  = (HOLD && m_held >= 0) ? (NOTE_TAB[m_held] >> m_oct) : 0;
            end
            up = m_db[13] && !m_prev[13];
            dn = m_db[14] && !m_prev[14];
            if (up && !dn && m_oct < 4) m_oct++;
            if (dn && !up && m_oct > 0) m_oct--;
            if (m_db[15] && !m_prev[15]) m_mode = (m_mode + 1) % 4;
            // A debounced bit flips once the synchronised input (two samples late)
            // has disagreed with it for D consecutive samples.
            hist.push_front({mode_btn, octave_down, octave_up, keys});
            void'(hist.pop_back());
            old_db = m_db;
            for (int i = 0; i < 16; i++) begin
                stable = 1'b1;
                for (int j = 2; j < D + 2; j++)
                    if (hist[j][i] == old_db[i]) stable = 1'b0;
                if (stable) m_db[i] = ~old_db[i];
            end
            m_prev = old_db;
        end
        exp_q.push_back('{div: 18'(m_div), mode: 2'(m_mode), note: m_note, oct: 3'(m_oct)});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                a = '{div: divider, mode: mode, note: note_on, oct: octave};
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard @%0t: got div=%0d mode=%0d note=%0d oct=%0d, expected div=%0d mode=%0d note=%0d oct=%0d",
                             $time, a.div, a.mode, a.note, a.oct, e.div, e.mode, e.note, e.oct);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [2:0] oct_exp [3]  = '{3'd3, 3'd4, 3'd4};
        int         div_exp [3]  = '{19111, 9555, 9555};
        logic [1:0] mode_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int unsigned r;

        nrst = 1'b0; keys = 13'h1FFF; octave_up = 1'b0; octave_down = 1'b0; mode_btn = 1'b0;
        wait_cyc(3);
        check("reset_divider", 32'(divider), 32'd0);
        check("reset_mode",    32'(mode),    32'd0);
        check("reset_note_on", 32'(note_on), 32'd0);
        check("reset_octave",  32'(octave),  32'd2);
        nrst = 1'b1;
        wait_cyc(6);
        check("reacquire_early", 32'(divider), 32'd0);
        wait_cyc(1);
        check("reacquire_div",  32'(divider), 32'd19111);
        check("reacquire_note", 32'(note_on), 32'd1);

        keys = '0;
        wait_cyc(10);
        check("release_all", 32'(divider), HOLD ? 32'd19111 : 32'd0);

        keys = 13'h1 << 9;
        wait_cyc(6);
        check("key_a_early", 32'(divider), HOLD ? 32'd19111 : 32'd0);
        wait_cyc(1);
        check("key_a_div",  32'(divider), 32'd22727);
        check("key_a_note", 32'(note_on), 32'd1);
        keys = '0;
        wait_cyc(6);
        check("key_a_rel_early", 32'(divider), 32'd22727);
        wait_cyc(1);
        check("key_a_rel_div",  32'(divider), HOLD ? 32'd22727 : 32'd0);
        check("key_a_rel_note", 32'(note_on), 32'd0);

        keys = 13'h1;
        wait_cyc(3);
        keys = '0;
        wait_cyc(10);
        check("glitch_div",  32'(divider), HOLD ? 32'd22727 : 32'd0);
        check("glitch_note", 32'(note_on), 32'd0);

        keys = 13'h081;
        wait_cyc(7);
        check("priority_div", 32'(divider), 32'd25510);
        keys = 13'h001;
        wait_cyc(7);
        check("priority_drop", 32'(divider), 32'd38222);

        for (int p = 0; p < 3; p++) begin
            octave_up = 1'b1;
            wait_cyc(7);
            check("octave_up_oct", 32'(octave), 32'(oct_exp[p]));
            wait_cyc(1);
            check("octave_up_div", 32'(divider), 32'(div_exp[p]));
            octave_up = 1'b0;
            wait_cyc(8);
        end
        octave_up = 1'b1; octave_down = 1'b1;
        wait_cyc(8);
        check("octave_both", 32'(octave), 32'd4);
        octave_up = 1'b0; octave_down = 1'b0;
        wait_cyc(8);

        for (int p = 0; p < 5; p++) begin
            mode_btn = 1'b1;
            wait_cyc(7);
            check("mode_step", 32'(mode), 32'(mode_exp[p]));
            mode_btn = 1'b0;
            wait_cyc(8);
        end
        mode_btn = 1'b1;
        wait_cyc(100);
        check("mode_held", 32'(mode), 32'd2);
        mode_btn = 1'b0;
        wait_cyc(10);
        check("mode_held_rel", 32'(mode), 32'd2);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                nrst = 1'b0;
                wait_cyc($urandom_range(1, 3));
                nrst = 1'b1;
            end else if (r < 45) begin
                case ($urandom_range(0, 2))
                    0:       keys = '0;
                    1:       keys = 13'(1 << $urandom_range(0, 12));
                    default: keys = 13'($urandom);
                endcase
            end else if (r < 60) begin
                octave_up = ~octave_up;
            end else if (r < 75) begin
                octave_down = ~octave_down;
            end else if (r < 88) begin
                mode_btn = ~mode_btn;
            end else begin
                octave_up   = 1'($urandom_range(0, 1));
                octave_down = octave_up;
            end
            wait_cyc($urandom_range(1, 10));
        end

        keys = '0; octave_up = 1'b0; octave_down = 1'b0; mode_btn = 1'b0;
        wait_cyc(12);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
